// File: rtl/peripheral_apb4_master_queue.sv
// peripheral_apb4_master_queue
//  Queued APB4 master: buffers read/write commands in a small FIFO and issues
//  them back-to-back on APB4, returning one response per command with PSLVERR
//  and wait-state timeout status.
// Ports
//  PCLK, PRESET           clock, synchronous active-high reset
//  cmd_*                  command valid/ready port (write, addr, strb, wdata)
//  rsp_*                  response valid/ready port (rdata, err, timeout)
//  busy                   FIFO occupied, transfer in flight or response held
//  PSEL..PWDATA           APB4 request outputs (registered)
//  PRDATA PREADY PSLVERR  APB4 completion inputs
module peripheral_apb4_master_queue #(
    parameter int unsigned PADDR_SIZE = 16,
    parameter int unsigned PDATA_SIZE = 32,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_W = PDATA_SIZE / 8;
    localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic                  write;
        logic [PADDR_SIZE-1:0] addr;
        logic [STRB_W-1:0]     strb;
        logic [PDATA_SIZE-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    cmd_t              mem [CMD_DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              abort;
    logic [TO_W-1:0]   wait_cnt;
    state_t            state;

    assign head = mem[rd_ptr];
    assign push = cmd_valid && cmd_ready;
    assign busy = (count != '0) || (state != IDLE) || rsp_valid;

    // Pop decision: start from IDLE once the response slot is free, or chain
    // straight from a completing ACCESS when the consumer is taking responses.
    always_comb begin
        pop   = 1'b0;
        abort = 1'b0;
        case (state)
            IDLE:    pop = (count != '0) && !rsp_valid;
            ACCESS: begin
                pop   = PREADY && (count != '0) && rsp_ready;
                abort = !PREADY && (TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT - 1));
            end
            default: ;
        endcase
    end

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, strb: cmd_strb, wdata: cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            cmd_ready <= (count_next != CNT_W'(CMD_DEPTH));
        end
    end

    // APB sequencing and response register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PSTRB       <= '0;
            PWDATA      <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

            case (state)
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        PENABLE     <= 1'b0;
                        PSEL        <= 1'b0;
                        state       <= IDLE;
                    end else if (abort) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        PENABLE     <= 1'b0;
                        PSEL        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase

            // A pop overrides the IDLE fall-back above so PSEL stays high on chains.
            if (pop) begin
                PADDR    <= head.addr;
                PWRITE   <= head.write;
                PWDATA   <= head.write ? head.wdata : '0;
                PSTRB    <= head.write ? head.strb : '0;
                PSEL     <= 1'b1;
                PENABLE  <= 1'b0;
                wait_cnt <= '0;
                state    <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_apb4_master_queue.sv
// tb_peripheral_apb4_master_queue
//  Self-checking bench: directed scenarios plus a randomized run, all scored
//  against a transaction-level model (command queue, slave plans, response queue).
module tb_peripheral_apb4_master_queue;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic          PCLK;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [SW-1:0] cmd_strb;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    peripheral_apb4_master_queue #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct { bit wr; logic [AW-1:0] addr; logic [SW-1:0] strb; logic [DW-1:0] wdata; } cmd_s;
    typedef struct { int w; logic [DW-1:0] rdata; bit err; } plan_s;
    typedef struct { logic [DW-1:0] rdata; bit err; bit to; } rsp_s;

    cmd_s  pend_q[$];
    cmd_s  exp_cmd_q[$];
    plan_s plan_q[$];
    rsp_s  exp_rsp_q[$];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc = 0;
    int    acc = 0;
    int    setup_cyc = 0;
    int    last_push_cyc = 0;
    bit    rdy_policy = 1'b0;
    bit    gap_rand = 1'b0;
    bit    rsp_fresh = 1'b0;
    bit    prev_valid = 1'b0;
    bit    prev_ready = 1'b0;
    cmd_s  cur_cmd;
    plan_s cur_plan;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_s mk_cmd(bit wr, logic [AW-1:0] a, logic [SW-1:0] s, logic [DW-1:0] d);
        cmd_s c;
        c.wr = wr; c.addr = a; c.strb = s; c.wdata = d;
        return c;
    endfunction

    function automatic plan_s mk_plan(int w, logic [DW-1:0] d, bit e);
        plan_s p;
        p.w = w; p.rdata = d; p.err = e;
        return p;
    endfunction

    // Slave wait-state plan: mostly short, with both sides of the timeout boundary.
    function automatic plan_s rand_plan();
        int w;
        case ($urandom % 12)
            0:       w = int'(TMO) - 1;
            1:       w = int'(TMO);
            2:       w = int'(TMO) + 4;
            default: w = int'($urandom % 4);
        endcase
        return mk_plan(w, $urandom, ($urandom % 4) == 0);
    endfunction

    // One clock: sample at the falling edge, play slave, score responses, drive commands.
    task automatic step();
        rsp_s r;
        @(negedge PCLK);
        cyc++;

        if (PSEL && !PENABLE) begin
            if (exp_cmd_q.size() == 0) begin
                chk("setup_expected", 64'(exp_cmd_q.size()), 1);
            end else begin
                cur_cmd = exp_cmd_q.pop_front();
                chk("setup_paddr", PADDR, cur_cmd.addr);
                chk("setup_pwrite", PWRITE, cur_cmd.wr);
                chk("setup_pwdata", PWDATA, cur_cmd.wr ? cur_cmd.wdata : '0);
                chk("setup_pstrb", PSTRB, cur_cmd.wr ? cur_cmd.strb : '0);
            end
            cur_plan = (plan_q.size() != 0) ? plan_q.pop_front() : rand_plan();
            acc = 0;
            setup_cyc = cyc;
            if (cur_plan.w >= int'(TMO)) begin
                r.rdata = '0; r.err = 1'b1; r.to = 1'b1;
            end else begin
                r.rdata = cur_cmd.wr ? '0 : cur_plan.rdata; r.err = cur_plan.err; r.to = 1'b0;
            end
            exp_rsp_q.push_back(r);
            PREADY = 1'($urandom & 1); PRDATA = $urandom; PSLVERR = 1'($urandom & 1);
        end else if (PSEL && PENABLE) begin
            chk("access_paddr", PADDR, cur_cmd.addr);
            chk("access_pwrite", PWRITE, cur_cmd.wr);
            acc++;
            PREADY  = (acc > cur_plan.w);
            PRDATA  = PREADY ? cur_plan.rdata : $urandom;
            PSLVERR = PREADY ? cur_plan.err : 1'($urandom & 1);
        end else begin
            PREADY = 1'($urandom & 1); PRDATA = $urandom; PSLVERR = 1'($urandom & 1);
        end

        rsp_ready = rdy_policy;
        rsp_fresh = rsp_valid && (!prev_valid || prev_ready);
        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_expected", 64'(exp_rsp_q.size()), 1);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_rsp_q[0].rdata);
                chk("rsp_err", rsp_err, exp_rsp_q[0].err);
                chk("rsp_timeout", rsp_timeout, exp_rsp_q[0].to);
                if (rsp_ready) void'(exp_rsp_q.pop_front());
            end
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;

        if (pend_q.size() != 0 && (!gap_rand || ($urandom % 3) != 0)) begin
            cmd_valid = 1'b1;
            cmd_write = pend_q[0].wr;
            cmd_addr  = pend_q[0].addr;
            cmd_strb  = pend_q[0].strb;
            cmd_wdata = pend_q[0].wdata;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom & 1);
            cmd_addr  = AW'($urandom);
            cmd_strb  = SW'($urandom);
            cmd_wdata = $urandom;
        end
        // The push lands on the rising edge following this sample.
        if (!PRESET && cmd_valid && cmd_ready === 1'b1) begin
            exp_cmd_q.push_back(pend_q.pop_front());
            last_push_cyc = cyc;
        end
    endtask

    task automatic wait_rsp(input int max, output int acc_n);
        bit found;
        found = 1'b0;
        acc_n = 0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            if (PSEL && PENABLE) acc_n++;
            if (rsp_fresh) found = 1'b1;
        end
        chk("wait_rsp", found, 1);
    endtask

    task automatic drain(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            step();
            done = (pend_q.size() == 0) && (exp_cmd_q.size() == 0) &&
                   (exp_rsp_q.size() == 0) && !busy;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        int  n;
        bit  seen;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_strb = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        rdy_policy = 1'b1;

        // T1: reset held three edges with a command offered
        pend_q.push_back(mk_cmd(1'b1, 16'h0040, 4'h3, 32'h1111_2222));
        repeat (3) begin
            step();
            chk("t1_cmd_ready", cmd_ready, 0);
            chk("t1_psel", PSEL, 0);
            chk("t1_penable", PENABLE, 0);
            chk("t1_rsp_valid", rsp_valid, 0);
            chk("t1_busy", busy, 0);
        end
        chk("t1_not_pushed", 64'(pend_q.size()), 1);
        PRESET = 1'b0;
        step();
        chk("t1_cmd_ready_after", cmd_ready, 1);
        drain(100);

        // T2: single write, zero wait states, latency
        plan_q.push_back(mk_plan(0, 32'hA5A5_A5A5, 1'b0));
        pend_q.push_back(mk_cmd(1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF));
        wait_rsp(20, n);
        chk("t2_access_cycles", 64'(n), 1);
        chk("t2_setup_lat", 64'(setup_cyc - last_push_cyc), 2);
        chk("t2_rsp_lat", 64'(cyc - last_push_cyc), 4);
        chk("t2_rdata", rsp_rdata, 0);
        chk("t2_err", rsp_err, 0);
        drain(50);

        // T3: read with three wait states and a slave error
        plan_q.push_back(mk_plan(3, 32'h1234_5678, 1'b1));
        pend_q.push_back(mk_cmd(1'b0, 16'h0020, 4'hF, 32'hFFFF_0000));
        wait_rsp(20, n);
        chk("t3_access_cycles", 64'(n), 4);
        chk("t3_rdata", rsp_rdata, 32'h1234_5678);
        chk("t3_err", rsp_err, 1);
        chk("t3_timeout", rsp_timeout, 0);
        drain(50);

        // T4: fill the FIFO behind a held response, then stream four writes
        rdy_policy = 1'b0;
        plan_q.push_back(mk_plan(0, 32'hCAFE_0001, 1'b0));
        pend_q.push_back(mk_cmd(1'b0, 16'h0030, 4'h0, 32'h0));
        wait_rsp(20, n);
        for (int i = 0; i < 4; i++) begin
            plan_q.push_back(mk_plan(0, $urandom, 1'b0));
            pend_q.push_back(mk_cmd(1'b1, AW'(16'h0100 + 4 * i), SW'($urandom), $urandom));
        end
        for (int i = 0; i < 12 && pend_q.size() != 0; i++) begin
            step();
            chk("t4_stall_psel", PSEL, 0);
        end
        step();
        chk("t4_cmd_ready_full", cmd_ready, 0);
        chk("t4_busy", busy, 1);
        rdy_policy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step();
            seen = PSEL && !PENABLE;
        end
        chk("t4_start", seen, 1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t4_psel", PSEL, 1);
            chk("t4_penable", PENABLE, 64'(i % 2));
        end
        step();
        chk("t4_idle_psel", PSEL, 0);
        drain(50);

        // T5: stuck slave aborts after TMO access cycles, next command runs
        plan_q.push_back(mk_plan(int'(TMO) + 4, 32'h5555_AAAA, 1'b0));
        plan_q.push_back(mk_plan(0, 32'h0BAD_F00D, 1'b0));
        pend_q.push_back(mk_cmd(1'b1, 16'h0050, 4'hC, 32'h7777_8888));
        pend_q.push_back(mk_cmd(1'b0, 16'h0054, 4'hF, 32'h0));
        wait_rsp(40, n);
        chk("t5_access_cycles", 64'(n), 64'(TMO));
        chk("t5_psel", PSEL, 0);
        chk("t5_timeout", rsp_timeout, 1);
        chk("t5_err", rsp_err, 1);
        chk("t5_rdata", rsp_rdata, 0);
        wait_rsp(20, n);
        chk("t5_next_access", 64'(n), 1);
        chk("t5_next_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("t5_next_timeout", rsp_timeout, 0);
        drain(50);

        // T6: response back-pressure holds the engine, then reset mid-ACCESS
        rdy_policy = 1'b0;
        plan_q.push_back(mk_plan(0, 32'h0000_1111, 1'b0));
        plan_q.push_back(mk_plan(0, 32'h0000_2222, 1'b1));
        pend_q.push_back(mk_cmd(1'b0, 16'h0060, 4'hF, 32'h0));
        pend_q.push_back(mk_cmd(1'b0, 16'h0064, 4'hF, 32'h0));
        wait_rsp(20, n);
        repeat (6) begin
            step();
            chk("t6_psel_hold", PSEL, 0);
            chk("t6_rsp_held", rsp_valid, 1);
        end
        rdy_policy = 1'b1;
        wait_rsp(20, n);
        chk("t6_second_access", 64'(n), 1);
        chk("t6_second_rdata", rsp_rdata, 32'h0000_2222);
        drain(50);

        plan_q.push_back(mk_plan(30, 32'h3333_3333, 1'b0));
        pend_q.push_back(mk_cmd(1'b0, 16'h0070, 4'hF, 32'h0));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = PSEL && PENABLE;
        end
        chk("t6_reach_access", seen, 1);
        repeat (2) step();
        PRESET = 1'b1;
        step();
        chk("t6_rst_psel", PSEL, 0);
        chk("t6_rst_penable", PENABLE, 0);
        chk("t6_rst_rsp", rsp_valid, 0);
        chk("t6_rst_busy", busy, 0);
        exp_rsp_q.delete();
        exp_cmd_q.delete();
        plan_q.delete();
        PRESET = 1'b0;
        repeat (3) begin
            step();
            chk("t6_no_rsp", rsp_valid, 0);
        end
        chk("t6_ready_after", cmd_ready, 1);

        // Randomized traffic with gaps in the command stream
        gap_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pend_q.push_back(mk_cmd(1'($urandom & 1), AW'($urandom), SW'($urandom), $urandom));
        end
        drain(5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
